// File: rtl/fp_lane_multiplier.sv
// Pipelined multi-lane significand/integer multiplier: stage k folds multiplier chunk k
// into a 2*WIDTH accumulator, one new vector operation per cycle, per-thread squash.
module fp_lane_multiplier #(
    parameter int NUM_LANES        = 16,
    parameter int WIDTH            = 32,
    parameter int STAGES           = 4,
    parameter int TAG_WIDTH        = 8,
    parameter int THREAD_IDX_WIDTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [THREAD_IDX_WIDTH-1:0]       in_thread_idx,
    input  logic [TAG_WIDTH-1:0]              in_tag,
    input  logic                              in_signed,
    input  logic [NUM_LANES-1:0]              in_mask,
    input  logic [NUM_LANES*WIDTH-1:0]        in_multiplicand,
    input  logic [NUM_LANES*WIDTH-1:0]        in_multiplier,
    input  logic                              rollback_en,
    input  logic [THREAD_IDX_WIDTH-1:0]       rollback_thread_idx,
    output logic                              out_valid,
    output logic [THREAD_IDX_WIDTH-1:0]       out_thread_idx,
    output logic [TAG_WIDTH-1:0]              out_tag,
    output logic [NUM_LANES-1:0]              out_mask,
    output logic [NUM_LANES*2*WIDTH-1:0]      out_product,
    output logic [$clog2(STAGES+1)-1:0]       in_flight
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int PW    = 2 * WIDTH;
    localparam int CW    = $clog2(STAGES + 1);

    logic                        valid_q  [STAGES];
    logic [THREAD_IDX_WIDTH-1:0] thread_q [STAGES];
    logic [TAG_WIDTH-1:0]        tag_q    [STAGES];
    logic                        signed_q [STAGES];
    logic [NUM_LANES-1:0]        mask_q   [STAGES];
    logic [PW-1:0]               acc_q    [STAGES][NUM_LANES];
    logic [PW-1:0]               aext_q   [STAGES][NUM_LANES];
    logic [WIDTH-1:0]            mplr_q   [STAGES][NUM_LANES];

    // Values presented to each stage register: the issue port for stage 0, else the previous stage.
    logic                        src_valid  [STAGES];
    logic [THREAD_IDX_WIDTH-1:0] src_thread [STAGES];
    logic [TAG_WIDTH-1:0]        src_tag    [STAGES];
    logic                        src_signed [STAGES];
    logic [NUM_LANES-1:0]        src_mask   [STAGES];
    logic [PW-1:0]               src_acc    [STAGES][NUM_LANES];
    logic [PW-1:0]               src_aext   [STAGES][NUM_LANES];
    logic [WIDTH-1:0]            src_mplr   [STAGES][NUM_LANES];
    logic [PW-1:0]               acc_d      [STAGES][NUM_LANES];
    logic                        kill       [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign src_valid[gi]  = in_valid;
                assign src_thread[gi] = in_thread_idx;
                assign src_tag[gi]    = in_tag;
                assign src_signed[gi] = in_signed;
                assign src_mask[gi]   = in_mask;
                for (genvar li = 0; li < NUM_LANES; li++) begin : g_lane
                    logic [WIDTH-1:0] a_in;
                    assign a_in = in_multiplicand[li*WIDTH +: WIDTH];
                    assign src_aext[gi][li] = !in_mask[li] ? '0 :
                                              in_signed ? {{WIDTH{a_in[WIDTH-1]}}, a_in} :
                                                          {{WIDTH{1'b0}}, a_in};
                    assign src_mplr[gi][li] = in_mask[li] ? in_multiplier[li*WIDTH +: WIDTH] : '0;
                    assign src_acc[gi][li]  = '0;
                end
            end else begin : g_link
                assign src_valid[gi]  = valid_q[gi-1];
                assign src_thread[gi] = thread_q[gi-1];
                assign src_tag[gi]    = tag_q[gi-1];
                assign src_signed[gi] = signed_q[gi-1];
                assign src_mask[gi]   = mask_q[gi-1];
                for (genvar li = 0; li < NUM_LANES; li++) begin : g_lane
                    assign src_aext[gi][li] = aext_q[gi-1][li];
                    assign src_mplr[gi][li] = mplr_q[gi-1][li];
                    assign src_acc[gi][li]  = acc_q[gi-1][li];
                end
            end

            assign kill[gi] = rollback_en && (src_thread[gi] == rollback_thread_idx);

            for (genvar li = 0; li < NUM_LANES; li++) begin : g_pp
                logic [CHUNK-1:0] chunk;
                logic [PW-1:0]    pp;
                logic [PW-1:0]    corr;
                assign chunk = src_mplr[gi][li][gi*CHUNK +: CHUNK];
                assign pp    = src_aext[gi][li] * PW'(chunk);
                // A signed top chunk weighs its MSB as -2^(CHUNK-1): take A_ext << CHUNK back off.
                if (gi == STAGES - 1) begin : g_top
                    assign corr = (src_signed[gi] && chunk[CHUNK-1]) ? (src_aext[gi][li] << CHUNK) : '0;
                end else begin : g_low
                    assign corr = '0;
                end
                assign acc_d[gi][li] = src_acc[gi][li] + ((pp - corr) << (gi * CHUNK));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (!reset) begin
                valid_q[k] <= 1'b0;
            end else begin
                valid_q[k] <= src_valid[k] && !kill[k];
            end

            if (!reset) begin
                if (k == STAGES - 1) begin
                    thread_q[k] <= '0;
                    tag_q[k]    <= '0;
                    signed_q[k] <= 1'b0;
                    mask_q[k]   <= '0;
                    for (int l = 0; l < NUM_LANES; l++) begin
                        acc_q[k][l] <= '0;
                    end
                end
            end else if (src_valid[k]) begin
                thread_q[k] <= src_thread[k];
                tag_q[k]    <= src_tag[k];
                signed_q[k] <= src_signed[k];
                mask_q[k]   <= src_mask[k];
                for (int l = 0; l < NUM_LANES; l++) begin
                    acc_q[k][l]  <= acc_d[k][l];
                    aext_q[k][l] <= src_aext[k][l];
                    mplr_q[k][l] <= src_mplr[k][l];
                end
            end
        end
    end

    always_comb begin
        in_flight = '0;
        for (int k = 0; k < STAGES; k++) begin
            in_flight = in_flight + CW'(valid_q[k]);
        end
    end

    assign out_valid      = valid_q[STAGES-1];
    assign out_thread_idx = thread_q[STAGES-1];
    assign out_tag        = tag_q[STAGES-1];
    assign out_mask       = mask_q[STAGES-1];

    generate
        for (genvar li = 0; li < NUM_LANES; li++) begin : g_out
            assign out_product[li*PW +: PW] = acc_q[STAGES-1][li];
        end
    endgenerate
endmodule

// File: tb/tb_fp_lane_multiplier.sv
// Self-checking bench: default-parameter instance plus a STAGES sweep (1,2,8,32) sharing the
// same stimulus, all checked against a whole-number product reference.
module tb_fp_lane_multiplier;
    localparam int NL = 16;
    localparam int W  = 32;
    localparam int N_SWEEP = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, in_valid, in_signed, rollback_en;
    logic [1:0]     in_thread_idx, rollback_thread_idx;
    logic [7:0]     in_tag;
    logic [NL-1:0]  in_mask;
    logic [NL*W-1:0] in_a, in_b;

    logic            out_valid;
    logic [1:0]      out_thread_idx;
    logic [7:0]      out_tag;
    logic [NL-1:0]   out_mask;
    logic [NL*2*W-1:0] out_product;
    logic [2:0]      in_flight;

    logic            sw_valid [4];
    logic [1:0]      sw_thr   [4];
    logic [7:0]      sw_tag   [4];
    logic [NL-1:0]   sw_mask  [4];
    logic [NL*2*W-1:0] sw_prod [4];
    logic [7:0]      sw_fl    [4];

    int nchecks = 0;
    int nerrs   = 0;

    fp_lane_multiplier dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_thread_idx(in_thread_idx),
        .in_tag(in_tag), .in_signed(in_signed), .in_mask(in_mask),
        .in_multiplicand(in_a), .in_multiplier(in_b),
        .rollback_en(rollback_en), .rollback_thread_idx(rollback_thread_idx),
        .out_valid(out_valid), .out_thread_idx(out_thread_idx), .out_tag(out_tag),
        .out_mask(out_mask), .out_product(out_product), .in_flight(in_flight)
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 8 : 32;
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
            localparam int SWS = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 32;
            logic [$clog2(SWS+1)-1:0] fl;
            fp_lane_multiplier #(.STAGES(SWS)) u_sw (
                .clk(clk), .reset(reset), .in_valid(in_valid), .in_thread_idx(in_thread_idx),
                .in_tag(in_tag), .in_signed(in_signed), .in_mask(in_mask),
                .in_multiplicand(in_a), .in_multiplier(in_b),
                .rollback_en(rollback_en), .rollback_thread_idx(rollback_thread_idx),
                .out_valid(sw_valid[gi]), .out_thread_idx(sw_thr[gi]), .out_tag(sw_tag[gi]),
                .out_mask(sw_mask[gi]), .out_product(sw_prod[gi]), .in_flight(fl)
            );
            assign sw_fl[gi] = 8'(fl);
        end
    endgenerate

    // Reference: true product of the extended operands, modulo 2^64.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] x, y;
        x = s ? {{32{a[31]}}, a} : {32'd0, a};
        y = s ? {{32{b[31]}}, b} : {32'd0, b};
        return x * y;
    endfunction

    function automatic logic [NL*2*W-1:0] ref_vec(input logic [NL*W-1:0] a, input logic [NL*W-1:0] b,
                                                   input logic s, input logic [NL-1:0] m);
        logic [NL*2*W-1:0] r;
        for (int l = 0; l < NL; l++) begin
            r[l*64 +: 64] = m[l] ? ref_mul(a[l*32 +: 32], b[l*32 +: 32], s) : 64'd0;
        end
        return r;
    endfunction

    function automatic int diff_lane(input logic [NL*2*W-1:0] x, input logic [NL*2*W-1:0] y);
        for (int l = 0; l < NL; l++) begin
            if (x[l*64 +: 64] !== y[l*64 +: 64]) return l;
        end
        return 0;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_vec(output logic [NL*W-1:0] v);
        for (int l = 0; l < NL; l++) v[l*32 +: 32] = rnd32();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_op(input logic [1:0] thr, input logic [7:0] tag, input logic s,
                            input logic [NL-1:0] m, input logic [NL*W-1:0] a, input logic [NL*W-1:0] b);
        in_valid = 1'b1; in_thread_idx = thr; in_tag = tag; in_signed = s;
        in_mask = m; in_a = a; in_b = b;
    endtask

    task automatic go_idle();
        in_valid = 1'b0; rollback_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; rollback_en = 1'b0; rollback_thread_idx = 2'd0;
        issue_op(2'd1, 8'h55, 1'b0, 16'hFFFF, {NL{32'h1234_5678}}, {NL{32'h0000_0003}});
        step(); step();
        nchecks++; if (out_valid !== 1'b0) begin nerrs++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        nchecks++; if (in_flight !== 3'd0) begin nerrs++; $display("FAIL reset_in_flight got %0d exp 0", in_flight); end
        nchecks++; if (out_product !== '0) begin nerrs++; $display("FAIL reset_product lane %0d got %h exp 0", diff_lane(out_product, '0), out_product[diff_lane(out_product, '0)*64 +: 64]); end
        nchecks++; if ({out_tag, out_mask, out_thread_idx} !== 26'd0) begin nerrs++; $display("FAIL reset_sideband got tag %h mask %h thr %0d exp 0", out_tag, out_mask, out_thread_idx); end
        reset = 1'b1; go_idle();
        for (int k = 1; k <= 5; k++) begin
            step();
            nchecks++; if (out_valid !== 1'b0) begin nerrs++; $display("FAIL reset_drop cycle %0d got valid %b exp 0", k, out_valid); end
        end
    endtask

    task automatic test_unsigned_max();
        logic [NL*2*W-1:0] e;
        issue_op(2'd0, 8'hA5, 1'b0, 16'hFFFF, {NL{32'hFFFF_FFFF}}, {NL{32'hFFFF_FFFF}});
        e = ref_vec(in_a, in_b, 1'b0, 16'hFFFF);
        for (int k = 1; k <= 5; k++) begin
            step(); go_idle();
            nchecks++; if (out_valid !== (k == 4)) begin nerrs++; $display("FAIL umax_latency cycle %0d got valid %b exp %b", k, out_valid, k == 4); end
            if (k == 4) begin
                nchecks++; if (out_product !== e) begin nerrs++; $display("FAIL umax_product lane %0d got %h exp %h", diff_lane(out_product, e), out_product[diff_lane(out_product, e)*64 +: 64], e[diff_lane(out_product, e)*64 +: 64]); end
                nchecks++; if (out_product[15*64 +: 64] !== 64'hFFFF_FFFE_0000_0001) begin nerrs++; $display("FAIL umax_const got %h exp fffffffe00000001", out_product[15*64 +: 64]); end
                nchecks++; if (out_tag !== 8'hA5) begin nerrs++; $display("FAIL umax_tag got %h exp a5", out_tag); end
            end
        end
    endtask

    task automatic test_signed_corners();
        logic [31:0] la [4];
        logic [31:0] lb [4];
        logic [63:0] lc [3];
        logic [NL*W-1:0] a, b;
        logic [NL-1:0] m;
        logic [NL*2*W-1:0] e;
        la = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'h0};
        lb = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0005, 32'h0};
        lc = '{64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF1};
        for (int t = 0; t < 4; t++) begin
            if (t < 3) begin
                a = {NL{la[t]}}; b = {NL{lb[t]}}; m = 16'hFFFF;
            end else begin
                rand_vec(a); rand_vec(b); m = 16'hAAAA;
            end
            issue_op(2'd2, 8'(8'h20 + t), 1'b1, m, a, b);
            e = ref_vec(a, b, 1'b1, m);
            step(); go_idle(); step(); step(); step();
            nchecks++; if (out_valid !== 1'b1) begin nerrs++; $display("FAIL signed_valid case %0d got %b exp 1", t, out_valid); end
            nchecks++; if (out_product !== e) begin nerrs++; $display("FAIL signed_product case %0d lane %0d got %h exp %h", t, diff_lane(out_product, e), out_product[diff_lane(out_product, e)*64 +: 64], e[diff_lane(out_product, e)*64 +: 64]); end
            if (t < 3) begin
                nchecks++; if (out_product[7*64 +: 64] !== lc[t]) begin nerrs++; $display("FAIL signed_const case %0d got %h exp %h", t, out_product[7*64 +: 64], lc[t]); end
            end else begin
                nchecks++; if (out_product[0 +: 64] !== 64'd0 || out_mask !== 16'hAAAA) begin nerrs++; $display("FAIL masked_lane got lane0 %h mask %h exp 0 aaaa", out_product[0 +: 64], out_mask); end
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [NL*W-1:0] a, b;
        logic [NL*2*W-1:0] e [4];
        int cnt;
        for (int n = 0; n < 8; n++) begin
            if (n < 4) begin
                rand_vec(a); rand_vec(b);
                issue_op(2'(n), 8'(n + 1), 1'(n % 2), 16'hFFFF, a, b);
                e[n] = ref_vec(a, b, 1'(n % 2), 16'hFFFF);
            end else begin
                go_idle();
            end
            step();
            cnt = 0;
            for (int j = 0; j < 4; j++) if (j <= n && j >= n - 3) cnt++;
            nchecks++; if (in_flight !== 3'(cnt)) begin nerrs++; $display("FAIL b2b_in_flight step %0d got %0d exp %0d", n, in_flight, cnt); end
            nchecks++; if (out_valid !== (n >= 3 && n <= 6)) begin nerrs++; $display("FAIL b2b_valid step %0d got %b exp %b", n, out_valid, n >= 3 && n <= 6); end
            if (n >= 3 && n <= 6) begin
                nchecks++; if (out_tag !== 8'(n - 2)) begin nerrs++; $display("FAIL b2b_tag step %0d got %0d exp %0d", n, out_tag, n - 2); end
                nchecks++; if (out_product !== e[n-3]) begin nerrs++; $display("FAIL b2b_product step %0d lane %0d got %h exp %h", n, diff_lane(out_product, e[n-3]), out_product[diff_lane(out_product, e[n-3])*64 +: 64], e[n-3][diff_lane(out_product, e[n-3])*64 +: 64]); end
            end
        end
    endtask

    task automatic test_rollback();
        logic [1:0] thr [4];
        logic alive [4];
        logic [NL*W-1:0] a, b;
        int cnt;
        thr = '{2'd0, 2'd1, 2'd0, 2'd1};
        for (int j = 0; j < 4; j++) alive[j] = (thr[j] != 2'd1);
        rollback_thread_idx = 2'd1;
        for (int n = 0; n < 8; n++) begin
            if (n < 4) begin
                rand_vec(a); rand_vec(b);
                issue_op(thr[n], 8'(10 + n), 1'b0, 16'hFFFF, a, b);
                rollback_en = (n == 3);
            end else begin
                go_idle();
            end
            step();
            cnt = 0;
            for (int j = 0; j < 4; j++) if (j <= n && j >= n - 3 && (alive[j] || n < 3)) cnt++;
            nchecks++; if (in_flight !== 3'(cnt)) begin nerrs++; $display("FAIL rb_in_flight step %0d got %0d exp %0d", n, in_flight, cnt); end
            if (n >= 3 && n <= 6) begin
                nchecks++; if (out_valid !== alive[n-3]) begin nerrs++; $display("FAIL rb_valid step %0d got %b exp %b", n, out_valid, alive[n-3]); end
                if (alive[n-3]) begin
                    nchecks++; if (out_tag !== 8'(10 + n - 3)) begin nerrs++; $display("FAIL rb_tag step %0d got %0d exp %0d", n, out_tag, 10 + n - 3); end
                end
            end else begin
                nchecks++; if (out_valid !== 1'b0) begin nerrs++; $display("FAIL rb_idle step %0d got %b exp 0", n, out_valid); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [NL*W-1:0] a, b;
        logic [NL*2*W-1:0] e;
        for (int n = 0; n < 3; n++) begin
            rand_vec(a); rand_vec(b);
            issue_op(2'd3, 8'(40 + n), 1'b1, 16'hFFFF, a, b);
            step();
        end
        go_idle(); reset = 1'b0;
        step();
        reset = 1'b1;
        nchecks++; if (out_valid !== 1'b0) begin nerrs++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
        nchecks++; if (in_flight !== 3'd0) begin nerrs++; $display("FAIL midrst_in_flight got %0d exp 0", in_flight); end
        nchecks++; if (out_product !== '0) begin nerrs++; $display("FAIL midrst_product lane %0d got %h exp 0", diff_lane(out_product, '0), out_product[diff_lane(out_product, '0)*64 +: 64]); end
        rand_vec(a); rand_vec(b);
        issue_op(2'd2, 8'h77, 1'b1, 16'h0F0F, a, b);
        e = ref_vec(a, b, 1'b1, 16'h0F0F);
        for (int k = 1; k <= 4; k++) begin
            step(); go_idle();
            nchecks++; if (out_valid !== (k == 4)) begin nerrs++; $display("FAIL midrst_latency cycle %0d got %b exp %b", k, out_valid, k == 4); end
        end
        nchecks++; if (out_product !== e || out_tag !== 8'h77) begin nerrs++; $display("FAIL midrst_result lane %0d got %h tag %h exp %h tag 77", diff_lane(out_product, e), out_product[diff_lane(out_product, e)*64 +: 64], out_tag, e[diff_lane(out_product, e)*64 +: 64]); end
    endtask

    logic [NL*2*W-1:0] sw_exp [N_SWEEP];
    logic [7:0]        sw_etag [N_SWEEP];
    logic [1:0]        sw_ethr [N_SWEEP];
    logic [NL-1:0]     sw_emask [N_SWEEP];

    task automatic test_param_sweep();
        logic [NL*W-1:0] a, b;
        logic s;
        logic [NL-1:0] m;
        int j, lo, hi, L, fails_before;
        go_idle(); reset = 1'b0; step(); reset = 1'b1;
        for (int i = 0; i < N_SWEEP + 32; i++) begin
            if (i < N_SWEEP) begin
                rand_vec(a); rand_vec(b);
                s = 1'($urandom_range(0, 1));
                m = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
                issue_op(2'($urandom_range(0, 3)), 8'(i), s, m, a, b);
                sw_exp[i] = ref_vec(a, b, s, m);
                sw_etag[i] = 8'(i); sw_ethr[i] = in_thread_idx; sw_emask[i] = m;
            end else begin
                go_idle();
            end
            step();
            for (int d = 0; d < 4; d++) begin
                L = lat(d);
                j = i - L + 1;
                lo = (i - L + 1 < 0) ? 0 : i - L + 1;
                hi = (i < N_SWEEP - 1) ? i : N_SWEEP - 1;
                nchecks++; if (sw_fl[d] !== 8'((hi >= lo) ? hi - lo + 1 : 0)) begin nerrs++; $display("FAIL sweep_in_flight S=%0d cyc %0d got %0d exp %0d", L, i, sw_fl[d], (hi >= lo) ? hi - lo + 1 : 0); end
                if (j >= 0 && j < N_SWEEP) begin
                    fails_before = nerrs;
                    nchecks++; if (sw_valid[d] !== 1'b1) begin nerrs++; $display("FAIL sweep_latency S=%0d op %0d got valid %b exp 1", L, j, sw_valid[d]); end
                    nchecks++; if (sw_prod[d] !== sw_exp[j]) begin nerrs++; $display("FAIL sweep_product S=%0d op %0d lane %0d got %h exp %h", L, j, diff_lane(sw_prod[d], sw_exp[j]), sw_prod[d][diff_lane(sw_prod[d], sw_exp[j])*64 +: 64], sw_exp[j][diff_lane(sw_prod[d], sw_exp[j])*64 +: 64]); end
                    nchecks++; if ({sw_tag[d], sw_thr[d], sw_mask[d]} !== {sw_etag[j], sw_ethr[j], sw_emask[j]}) begin nerrs++; $display("FAIL sweep_sideband S=%0d op %0d got tag %h thr %0d mask %h exp tag %h thr %0d mask %h", L, j, sw_tag[d], sw_thr[d], sw_mask[d], sw_etag[j], sw_ethr[j], sw_emask[j]); end
                    if (nerrs - fails_before > 0 && nerrs > 50) begin
                        $display("FAIL sweep_abort too many failures, %0d so far", nerrs);
                        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nerrs);
                        $fatal(1);
                    end
                end else begin
                    nchecks++; if (sw_valid[d] !== 1'b0) begin nerrs++; $display("FAIL sweep_idle S=%0d cyc %0d got valid %b exp 0", L, i, sw_valid[d]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_corners();
        test_back_to_back();
        test_rollback();
        test_reset_midflight();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nerrs);
        $finish;
    end
endmodule
